// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode names and issue-stage FSM encoding.
// Imported by the issue controller and its register file.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;

    localparam int OP_ILLEGAL_BIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: r0 reads as zero, two operand reads plus a debug read,
// and one merged write port where a write-back beats a host write to the same address.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rdAddrA_i,
    input  logic [REG_AW-1:0] rdAddrB_i,
    input  logic [REG_AW-1:0] dbgAddr_i,
    output logic [DATA_W-1:0] rdDataA_o,
    output logic [DATA_W-1:0] rdDataB_o,
    output logic [DATA_W-1:0] dbgData_o,
    input  logic              wbEn_i,
    input  logic [REG_AW-1:0] wbAddr_i,
    input  logic [DATA_W-1:0] wbData_i,
    input  logic              hostEn_i,
    input  logic [REG_AW-1:0] hostAddr_i,
    input  logic [DATA_W-1:0] hostData_i
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              hostBlocked;
    logic              hostWrite;
    logic              wbWrite;

    assign hostBlocked = wbEn_i && (wbAddr_i == hostAddr_i);
    assign hostWrite   = hostEn_i && (hostAddr_i != '0) && !hostBlocked;
    assign wbWrite     = wbEn_i && (wbAddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (hostWrite) begin
                regs_q[hostAddr_i] <= hostData_i;
            end
            if (wbWrite) begin
                regs_q[wbAddr_i] <= wbData_i;
            end
        end
    end

    // r0 is never written, but masking the reads keeps it zero by construction
    assign rdDataA_o = (rdAddrA_i == '0) ? '0 : regs_q[rdAddrA_i];
    assign rdDataB_o = (rdAddrB_i == '0) ? '0 : regs_q[rdAddrB_i];
    assign dbgData_o = (dbgAddr_i == '0) ? '0 : regs_q[dbgAddr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue operand/issue stage wrapped around an external combinational ALU.
// Accept -> EXEC (drive ALU, capture result) -> WB (done pulse, register write).
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_imm_en,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              host_wr_en,
    input  logic [REG_AW-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic [DATA_W-1:0] alu_bus_in1,
    output logic [DATA_W-1:0] alu_bus_in2,
    output logic [3:0]        alu_control,
    output logic              alu_reset,
    input  logic [DATA_W-1:0] alu_bus_out,
    output logic              done,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic              readyArmed_q;
    logic              instrReady_q;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] opA_q;
    logic [DATA_W-1:0] opB_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rs1Data;
    logic [DATA_W-1:0] rs2Data;
    logic              accept;
    logic              wbEn;
    logic              opIllegal;

    assign opIllegal = op_q[OP_ILLEGAL_BIT];

    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (reset_n),
        .rdAddrA_i  (instr_rs1),
        .rdAddrB_i  (instr_rs2),
        .dbgAddr_i  (dbg_addr),
        .rdDataA_o  (rs1Data),
        .rdDataB_o  (rs2Data),
        .dbgData_o  (dbg_data),
        .wbEn_i     (wbEn),
        .wbAddr_i   (rd_q),
        .wbData_i   (result_q),
        .hostEn_i   (host_wr_en),
        .hostAddr_i (host_wr_addr),
        .hostData_i (host_wr_data)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        wbEn        = 1'b0;
        alu_control = '0;
        alu_reset   = 1'b1;
        done        = 1'b0;
        done_rd     = '0;
        done_data   = '0;
        illegal     = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid && instrReady_q) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_control = op_q;
                alu_reset   = 1'b0;
                state_d     = WB;
            end
            WB: begin
                done      = 1'b1;
                done_rd   = rd_q;
                done_data = opIllegal ? '0 : result_q;
                illegal   = opIllegal;
                wbEn      = !opIllegal;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // readyArmed_q holds instr_ready low through the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readyArmed_q <= 1'b0;
            instrReady_q <= 1'b0;
        end else begin
            readyArmed_q <= 1'b1;
            instrReady_q <= readyArmed_q && (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            rd_q     <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= instr_op;
                rd_q  <= instr_rd;
                opA_q <= rs1Data;
                opB_q <= instr_imm_en ? instr_imm : rs2Data;
            end
            if (state_q == EXEC) begin
                result_q <= alu_bus_out;
            end
        end
    end

    assign instr_ready = instrReady_q;
    assign alu_bus_in1 = opA_q;
    assign alu_bus_in2 = opB_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Single-issue operand/issue stage that sits directly around the 16-bit combinational ALU. It accepts one instruction per valid/ready handshake and reads operands from an 8-entry register file. It drives the ALU's bus_in1, bus_in2 and control inputs for exactly one cycle, captures bus_out, and writes the result back. Throughput is one instruction per 3 cycles; no pipelining or bypass is needed.

Parameters:
DATA_W, 16, datapath width; must match the ALU bus width.
NREGS, 8, number of registers; r0 is hardwired to zero.
REG_AW, 3, register address width; equals log2(NREGS).

Ports:
clk  in  1  single clock, all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  stage can accept an instruction
instr_op  in  4  ALU control code; bit3 set = illegal
instr_rd  in  REG_AW  destination register
instr_rs1  in  REG_AW  source register A
instr_rs2  in  REG_AW  source register B
instr_imm_en  in  1  operand B comes from instr_imm instead of rs2
instr_imm  in  DATA_W  immediate operand
host_wr_en  in  1  host register write
host_wr_addr  in  REG_AW  host write address
host_wr_data  in  DATA_W  host write data
alu_bus_in1  out  DATA_W  to ALU bus_in1
alu_bus_in2  out  DATA_W  to ALU bus_in2
alu_control  out  4  to ALU control
alu_reset  out  1  to ALU reset (active-high); forces ALU output to zero
alu_bus_out  in  DATA_W  from ALU bus_out
done  out  1  one-cycle pulse at write-back
done_rd  out  REG_AW  destination of the completed instruction
done_data  out  DATA_W  result of the completed instruction
illegal  out  1  pulses together with done for an illegal opcode
dbg_addr  in  REG_AW  debug read address
dbg_data  out  DATA_W  combinational read of regs[dbg_addr]; reads 0 for r0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; instr_ready=0.
  - All registers, operand latches and result latch cleared to 0.
  - Outputs: done=0, illegal=0, done_rd=0, done_data=0, alu_bus_in1=0, alu_bus_in2=0, alu_control=0, alu_reset=1.
- instr_ready is a registered flag.
  - Stays 0 during reset and through the first rising edge after release.
  - Goes 1 on the next edge, then equals (state==IDLE).
- FSM states: IDLE, EXEC, WB.
  - IDLE: on a rising edge with instr_valid & instr_ready (cycle T):
    - Latch op and rd.
    - opA = regs[rs1].
    - opB = imm_en ? imm : regs[rs2].
    - Register values are those before edge T; a same-edge host write is not forwarded.
    - Go to EXEC.
  - EXEC (cycle T+1):
    - alu_bus_in1 = opA, alu_bus_in2 = opB, alu_control = op, alu_reset = 0.
    - At the end of the cycle, capture alu_bus_out into the result latch.
    - Go to WB.
  - WB (cycle T+2):
    - done=1, done_rd=rd, done_data=result.
    - On the closing edge, write regs[rd] = result unless rd==0 or op[3]==1.
    - Go to IDLE. instr_ready returns to 1 in cycle T+3.
- Outside EXEC: alu_reset=1, alu_control=0, ALU operand outputs hold their last values.
- Illegal opcode (op[3]=1):
  - Accepted and sequenced normally through EXEC and WB.
  - ALU output is 0 because control[3] is set.
  - In WB: done=1, illegal=1, done_data=0, no register write.
- Arithmetic: all widths DATA_W. Results wrap modulo 2^16; no carry or overflow output.
- Host write port:
  - Writes on any edge when host_wr_en=1; a write to r0 is ignored.
  - Same-edge collision with the WB write to the same address: the WB write wins and the host write is dropped.
  - Collision at different addresses: both writes land.
- instr_valid while instr_ready=0 is ignored, not queued; the upstream holds its instruction.
- reset_n asserted mid-instruction (EXEC or WB): instruction aborted, no done pulse, no write, full reset values as above.

Decomposition:
- Shared package alu_pkg:
  - DATA_W, REG_AW.
  - Opcode constants: OP_ADD=4'h1, OP_SUB=4'h2; the remaining ALU codes 0–7 as named constants.
  - OP_ILLEGAL_BIT=3.
  - FSM state encoding IDLE/EXEC/WB.
- One sub-module, alu_regfile:
  - NREGS x DATA_W storage, r0 forced to zero.
  - Two combinational read ports plus a debug read port.
  - One merged write port with WB-over-host priority.
  - Asynchronous active-low clear.
- The ALU itself is instantiated by the parent; this block is not merged with it.

Test Plan:
1. Hold reset_n=0 for 3 cycles, then release -> instr_ready=0 through the first edge after release and 1 afterwards; alu_reset=1; dbg_data=0 for every dbg_addr.
2. Host writes r1=0x0005, r2=0x0003; then ADD(op 1) rd=3 rs1=1 rs2=2 accepted at T -> alu_control=1 only in T+1; done=1 in T+2 with done_rd=3, done_data=0x0008; dbg r3=0x0008; instr_ready=1 in T+3.
3. SUB(op 2) rd=4 rs1=2 rs2=1 -> done_data=0xFFFE (wrap); r4=0xFFFE.
4. ADD with imm_en=1, imm=0xFFFF, rs1=1 -> done_data=0x0004 (carry dropped). Then ADD rd=0 -> done pulses but dbg r0 stays 0.
5. Opcode 4'h9 -> done=1 with illegal=1 and done_data=0; rd unchanged. Host write to r5=0x1234 on the same edge as a WB to r5 -> r5 holds the WB result.
6. reset_n pulsed low during EXEC -> no done pulse; all registers 0; instr_ready=0 until one edge after release; instr_valid held high throughout is accepted only once ready=1.
